// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp,
      StDone
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extract/extend.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]        i_funct3,
   input  logic [1:0]        i_addr_lo,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_bus_rdata,
   output logic [3:0]        o_be,
   output logic [DATA_W-1:0] o_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] w_shift;

   assign w_shift = i_bus_rdata >> {i_addr_lo, 3'b000};

   // Access size lives in funct3[1:0] for both loads and stores.
   always_comb begin
      o_be    = BE_WORD;
      o_wdata = i_wdata;
      case (i_funct3[1:0])
         F3_SB[1:0]: begin
            o_be    = BE_BYTE << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         F3_SH[1:0]: begin
            o_be    = BE_HALF << i_addr_lo;
            o_wdata = {2{i_wdata[15:0]}};
         end
         default: begin
            o_be    = BE_WORD;
            o_wdata = i_wdata;
         end
      endcase
   end

   always_comb begin
      o_rdata = i_bus_rdata;
      case (i_funct3)
         F3_LB:   o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_LBU:  o_rdata = {24'd0, w_shift[7:0]};
         F3_LH:   o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_LHU:  o_rdata = {16'd0, w_shift[15:0]};
         default: o_rdata = i_bus_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and a handshaked data bus.
// Optional watchdog on gnt/rvalid waits enabled by LSU_TIMEOUT_EN.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_is_store,
   input  logic [2:0]        i_funct3,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_stall,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_err,
   output logic              o_bus_req,
   output logic              o_bus_we,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [3:0]        o_bus_be,
   output logic [DATA_W-1:0] o_bus_wdata,
   input  logic              i_bus_gnt,
   input  logic              i_bus_rvalid,
   input  logic [DATA_W-1:0] i_bus_rdata
);

   lsu_state_t        r_state;
   lsu_state_t        w_state_nxt;
   logic              r_is_store;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   logic              w_accept;
   logic              w_illegal;
   logic              w_misal;
   logic              w_bad;
   logic              w_timeout;
   logic              w_wd_expired;
   logic              w_in_req;
   logic              w_load_done;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_bwdata;
   logic [DATA_W-1:0] w_ext;

   lsu_align u_align (
      .i_funct3    (r_funct3),
      .i_addr_lo   (r_addr[1:0]),
      .i_wdata     (r_wdata),
      .i_bus_rdata (i_bus_rdata),
      .o_be        (w_be),
      .o_wdata     (w_bwdata),
      .o_rdata     (w_ext)
   );

   always_comb begin
      w_illegal = i_is_store ? (i_funct3 > 3'd2)
                             : (i_funct3 == 3'd3 || i_funct3[2:1] == 2'b11);
      w_misal   = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                  (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
      w_bad     = w_illegal || w_misal;
   end

   assign w_accept = (r_state == StIdle) && i_start;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CntW-1:0] r_wdog;

   assign w_wd_expired = (r_wdog == CntW'(TIMEOUT_CYC - 1));

   // Counter restarts on every entry into a waiting state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wdog <= '0;
      end else if (w_accept || (r_state == StReq && i_bus_gnt)) begin
         r_wdog <= '0;
      end else if (r_state == StReq || r_state == StResp) begin
         r_wdog <= r_wdog + CntW'(1);
      end
   end
`else
   assign w_wd_expired = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) w_state_nxt = w_bad ? StDone : StReq;
         end
         StReq: begin
            if (i_bus_gnt) begin
               w_state_nxt = r_is_store ? StDone : StResp;
            end else if (w_wd_expired) begin
               w_state_nxt = StDone;
               w_timeout   = 1'b1;
            end
         end
         StResp: begin
            if (i_bus_rvalid) begin
               w_state_nxt = StDone;
            end else if (w_wd_expired) begin
               w_state_nxt = StDone;
               w_timeout   = 1'b1;
            end
         end
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   assign w_load_done = (r_state == StResp) && i_bus_rvalid;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_is_store <= 1'b0;
         r_funct3   <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_is_store <= i_is_store;
            r_funct3   <= i_funct3;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            r_err      <= w_bad;
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end
         if (w_load_done) r_rdata <= w_ext;
      end
   end

   // Bus fields come straight from the op registers, so they hold until gnt.
   assign w_in_req    = (r_state == StReq);
   assign o_bus_req   = w_in_req;
   assign o_bus_we    = w_in_req & r_is_store;
   assign o_bus_addr  = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign o_bus_be    = w_in_req ? w_be : 4'b0000;
   assign o_bus_wdata = w_in_req ? w_bwdata : '0;

   assign o_done  = (r_state == StDone);
   assign o_err   = o_done & r_err;
   assign o_rdata = r_rdata;
   assign o_stall = w_accept || (r_state == StReq) || (r_state == StResp);

endmodule
